mlp_in_packer: RTL and testbench
================================

// Module: mlp_in_packer
// PURPOSE
// Transmit side of the mlp_98 input interface. Accepts a serial stream of N1 feature words per frame.
// Packs words 0..N1/2-1 into in_mag and words N1/2..N1-1 into in_pol, and presents the frame to the
// free-running MLP core with a one-cycle frame_valid strobe. Sits between the pixel/feature front end
// and the MLP; enforces frame integrity and a minimum issue spacing.
// PARAMETERS
// N1       98  features per frame (even); N1/2 magnitude lanes, N1/2 polarity lanes
// W_X       4  feature word width; magnitude lanes keep all W_X bits, polarity lanes keep bit 0
// MIN_GAP   1  min cycles between consecutive frame_valid pulses (>=1)
// PORTS
// clk          in   1          clock, all logic on posedge
// rst          in   1          synchronous reset, active-high
// s_valid      in   1          feature word valid
// s_ready      out  1          packer can accept a word
// s_data       in   W_X        feature word
// s_last       in   1          last word of frame marker
// in_mag       out  N1/2*W_X   packed magnitudes, lane i = word i
// in_pol       out  N1/2       packed polarities, lane i = bit 0 of word N1/2+i
// frame_valid  out  1          1-cycle strobe: in_mag/in_pol just updated with a new frame
// frame_err    out  1          1-cycle strobe: malformed frame discarded
// BEHAVIOUR
// - Reset: in_mag=0, in_pol=0, frame_valid=0, frame_err=0, s_ready=0 while rst=1, word index=0, state FILL,
//   gap counter saturated (first frame may issue immediately). Partial frames in progress are discarded.
// - Transfer when s_valid&&s_ready. Fill buffer (separate from output regs) written at word index idx; idx++.
// - Output regs in_mag/in_pol are held stable between frame_valid pulses (MLP samples every cycle).
// - States:
//   FILL  s_ready=1. Accept word idx. If idx==N1-1 && s_last: frame complete -> issue if gap ok, else WAIT.
//         If s_last && idx<N1-1: frame_err pulse next cycle, idx=0, stay FILL (short frame dropped).
//         If idx==N1-1 && !s_last: frame_err pulse, go DRAIN (long frame).
//   WAIT  s_ready=0; complete frame in fill buffer; issue when gap ok, then FILL.
//   DRAIN s_ready=1; discard words until an s_last transfer, then idx=0, FILL. No further frame_err.
// - Issue: copy fill buffer to output regs; frame_valid=1 in the same cycle the new values appear.
//   Latency: last word accepted at cycle t -> outputs/frame_valid at t+1 when gap ok.
// - Gap: frame_valid pulses are >= MIN_GAP cycles apart. With MIN_GAP=1 back-to-back frames run with
//   no stall: a word for the next frame may be accepted in the issue cycle.
// - Polarity words: bits [W_X-1:1] ignored. Magnitude words are stored unmodified (signed two's complement per MLP).
// - Issue and a new frame's first word in the same cycle are legal; the fill buffer is overwritten only after its copy.
// CONFIGURATION
// MLP_IN_PACKER_ERRCNT_EN defined: extra output err_count (16-bit). Increments on each frame_err and
//   saturates at 0xFFFF; cleared by rst.
// MLP_IN_PACKER_ERRCNT_EN undefined: no err_count port or counter; frame_err strobe only.
// STRUCTURE
// - mlp_pkg: N1, W_X defaults shared with mlp_98, and typedef enum {FILL,WAIT,DRAIN} packer_state_t.
// - Sub-module mlp_issue_throttle: MIN_GAP gap counter. Inputs: issue pulse. Output: gap_ok.
// - The rest stays flat: fill buffer, index counter, FSM, output regs.
// TESTING
// - rst 3 cycles, then 98 words (words 0..48=4'h3, 49..97=4'h1), s_last on word 97 -> frame_valid 1 cycle after;
//   in_mag lanes all 3, in_pol all 1s.
// - Two frames back-to-back, MIN_GAP=1, s_valid always 1 -> s_ready never drops; frame_valid pulses exactly 98 cycles apart.
// - MIN_GAP=200, two back-to-back frames -> second frame: s_ready=0 in WAIT; pulses exactly 200 cycles apart; outputs held between pulses.
// - s_last on word 10 -> frame_err pulse, no frame_valid, outputs unchanged; next good frame issues normally.
// - 98 words with no s_last, then 5 more with s_last on the 5th -> one frame_err; words dropped; next frame clean.
//   With MLP_IN_PACKER_ERRCNT_EN, err_count=1.
// - rst asserted after word 50 -> outputs 0, s_ready=0 during rst; next full frame issues with correct lanes.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared definitions for the mlp_98 input path: default frame geometry and packer FSM states.
package mlp_pkg;

    localparam int N1_DEFAULT  = 98;
    localparam int W_X_DEFAULT = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } packer_state_t;

endpackage

// File: rtl/mlp_issue_throttle.sv
// Enforces a minimum spacing of MIN_GAP cycles between consecutive frame issues.
// Counter starts saturated so the first frame after reset may issue at once.
module mlp_issue_throttle #(
    parameter int MIN_GAP = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic gap_ok
);

    localparam int              CW  = $clog2(MIN_GAP + 1);
    localparam logic [CW-1:0]   SAT = CW'(MIN_GAP);

    logic [CW-1:0] gap_cnt;

    // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= SAT;
        end else if (issue) begin
            gap_cnt <= CW'(1);
        end else if (gap_cnt != SAT) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign gap_ok = (gap_cnt == SAT);

endmodule

// File: rtl/mlp_in_packer.sv
// Packs a serial stream of N1 feature words into the parallel mlp_98 input lanes.
// Optional build macro MLP_IN_PACKER_ERRCNT_EN adds a saturating 16-bit err_count output.
module mlp_in_packer
    import mlp_pkg::*;
#(
    parameter int N1      = N1_DEFAULT,
    parameter int W_X     = W_X_DEFAULT,
    parameter int MIN_GAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [W_X-1:0]        s_data,
    input  logic                  s_last,
    output logic [N1/2*W_X-1:0]   in_mag,
    output logic [N1/2-1:0]       in_pol,
    output logic                  frame_valid,
    output logic                  frame_err
`ifdef MLP_IN_PACKER_ERRCNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    localparam int                HALF     = N1 / 2;
    localparam int                IDX_W    = $clog2(N1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N1 - 1);

    packer_state_t       state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HALF*W_X-1:0] mag_buf, mag_next;
    logic [HALF-1:0]     pol_buf, pol_next;
    logic                issue, err_d, gap_ok;

    mlp_issue_throttle #(.MIN_GAP(MIN_GAP)) u_throttle (
        .clk    (clk),
        .rst    (rst),
        .issue  (issue),
        .gap_ok (gap_ok)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        issue   = 1'b0;
        err_d   = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!s_last) begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end else if (gap_ok) begin
                            issue = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end else if (s_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (gap_ok) begin
                    issue   = 1'b1;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (rst) begin
            s_ready = 1'b0;
        end
    end

    // Buffer image including the word arriving this cycle, so the last word issues without a bubble.
    always_comb begin
        mag_next = mag_buf;
        pol_next = pol_buf;
        if (state_q == FILL && s_valid) begin
            for (int i = 0; i < HALF; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    mag_next[i*W_X +: W_X] = s_data;
                end
                if (idx_q == IDX_W'(HALF + i)) begin
                    pol_next[i] = s_data[0];
                end
            end
        end
    end

    // NOTE: the fill buffer has no reset; every lane is rewritten before any frame is copied out.
    always_ff @(posedge clk) begin
        mag_buf <= mag_next;
        pol_buf <= pol_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            in_mag      <= '0;
            in_pol      <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_valid <= issue;
            frame_err   <= err_d;
            if (issue) begin
                in_mag <= mag_next;
                in_pol <= pol_next;
            end
        end
    end

`ifdef MLP_IN_PACKER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_d && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_in_packer.sv
// Directed bench for mlp_in_packer: one instance with MIN_GAP=1, one with MIN_GAP=200.
module tb_mlp_in_packer;

    localparam int N1   = 98;
    localparam int W_X  = 4;
    localparam int HALF = N1 / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                a_valid = 1'b0, a_last = 1'b0;
    logic [W_X-1:0]      a_data  = '0;
    logic                a_ready, a_fv, a_fe;
    logic [HALF*W_X-1:0] a_mag;
    logic [HALF-1:0]     a_pol;

    logic                b_valid = 1'b0, b_last = 1'b0;
    logic [W_X-1:0]      b_data  = '0;
    logic                b_ready, b_fv, b_fe;
    logic [HALF*W_X-1:0] b_mag;
    logic [HALF-1:0]     b_pol;

`ifdef MLP_IN_PACKER_ERRCNT_EN
    logic [15:0] a_err_count, b_err_count;
`endif

    mlp_in_packer u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (a_valid),
        .s_ready     (a_ready),
        .s_data      (a_data),
        .s_last      (a_last),
        .in_mag      (a_mag),
        .in_pol      (a_pol),
        .frame_valid (a_fv),
        .frame_err   (a_fe)
`ifdef MLP_IN_PACKER_ERRCNT_EN
        ,
        .err_count   (a_err_count)
`endif
    );

    mlp_in_packer #(.MIN_GAP(200)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (b_valid),
        .s_ready     (b_ready),
        .s_data      (b_data),
        .s_last      (b_last),
        .in_mag      (b_mag),
        .in_pol      (b_pol),
        .frame_valid (b_fv),
        .frame_err   (b_fe)
`ifdef MLP_IN_PACKER_ERRCNT_EN
        ,
        .err_count   (b_err_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int a_fv_cnt = 0, a_fv_prev = 0, a_fv_last = 0, a_fe_cnt = 0;
    int b_fv_cnt = 0, b_fv_prev = 0, b_fv_last = 0;
    int a_stalls = 0, b_stalls = 0;
    logic a_timeout = 1'b0, b_timeout = 1'b0;

    always @(posedge clk) cyc++;

    // Pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_fv === 1'b1) begin
            a_fv_cnt++;
            a_fv_prev = a_fv_last;
            a_fv_last = cyc;
        end
        if (a_fe === 1'b1) a_fe_cnt++;
        if (b_fv === 1'b1) begin
            b_fv_cnt++;
            b_fv_prev = b_fv_last;
            b_fv_last = cyc;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame 0 is the all-3 / all-1 pattern; other frames use a per-frame arithmetic pattern.
    function automatic logic [W_X-1:0] gen_word(input int f, input int k);
        if (f == 0) return (k < HALF) ? 4'h3 : 4'h1;
        return 4'((k * 3 + f * 7 + 1) % 16);
    endfunction

    function automatic logic [HALF*W_X-1:0] exp_mag(input int f);
        logic [HALF*W_X-1:0] m;
        for (int i = 0; i < HALF; i++) m[i*W_X +: W_X] = gen_word(f, i);
        return m;
    endfunction

    function automatic logic [HALF-1:0] exp_pol(input int f);
        logic [HALF-1:0] p;
        logic [W_X-1:0]  w;
        for (int i = 0; i < HALF; i++) begin
            w    = gen_word(f, HALF + i);
            p[i] = w[0];
        end
        return p;
    endfunction

    task automatic a_send(input logic [W_X-1:0] d, input logic l);
        int n = 0;
        a_valid = 1'b1;
        a_data  = d;
        a_last  = l;
        while (a_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        a_stalls += n;
        if (n >= 1000) a_timeout = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic b_send(input logic [W_X-1:0] d, input logic l);
        int n = 0;
        b_valid = 1'b1;
        b_data  = d;
        b_last  = l;
        while (b_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        b_stalls += n;
        if (n >= 1000) b_timeout = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic a_frame(input int f, input int nw, input int last_at);
        for (int k = 0; k < nw; k++) a_send(gen_word(f, k), k == last_at);
    endtask

    task automatic b_frame(input int f, input int nw, input int last_at);
        for (int k = 0; k < nw; k++) b_send(gen_word(f, k), k == last_at);
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [HALF*W_X-1:0] mag3;
        logic [HALF-1:0]     pol1;
        int fv0, fe0;
        mag3 = {HALF{4'h3}};
        pol1 = {HALF{1'b1}};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_mag", a_mag, '0);
        chk("rst_pol", a_pol, '0);
        chk("rst_fv", a_fv, 1'b0);
        chk("rst_fe", a_fe, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
`ifdef MLP_IN_PACKER_ERRCNT_EN
        chk("rst_errcnt", a_err_count, 16'd0);
`endif
        rst = 1'b0;
        #1;
        chk("ready_after_rst", a_ready, 1'b1);

        // Basic frame: mag lanes all 3, pol lanes all 1, issue one cycle after last word
        a_frame(0, N1 - 1, -1);
        chk("basic_fv_early", a_fv, 1'b0);
        a_send(gen_word(0, N1 - 1), 1'b1);
        chk("basic_fv", a_fv, 1'b1);
        chk("basic_mag", a_mag, mag3);
        chk("basic_pol", a_pol, pol1);
        idle(1);
        chk("basic_fv_drop", a_fv, 1'b0);
        chk("basic_mag_hold", a_mag, mag3);
        chk("basic_stalls", a_stalls, 0);

        // Back-to-back frames with MIN_GAP=1: no stall, pulses 98 cycles apart
        fv0 = a_fv_cnt;
        a_frame(1, N1, N1 - 1);
        chk("b2b_fv1", a_fv, 1'b1);
        chk("b2b_mag1", a_mag, exp_mag(1));
        chk("b2b_pol1", a_pol, exp_pol(1));
        a_frame(2, N1, N1 - 1);
        chk("b2b_fv2", a_fv, 1'b1);
        chk("b2b_mag2", a_mag, exp_mag(2));
        chk("b2b_pol2", a_pol, exp_pol(2));
        idle(2);
        chk("b2b_pulses", a_fv_cnt - fv0, 2);
        chk("b2b_spacing", a_fv_last - a_fv_prev, 98);
        chk("b2b_stalls", a_stalls, 0);

        // Short frame (s_last on word 10): error strobe, outputs untouched
        fv0 = a_fv_cnt;
        fe0 = a_fe_cnt;
        a_frame(3, 11, 10);
        chk("short_fe", a_fe, 1'b1);
        chk("short_fv", a_fv, 1'b0);
        idle(1);
        chk("short_fe_drop", a_fe, 1'b0);
        chk("short_mag_hold", a_mag, exp_mag(2));
        chk("short_pol_hold", a_pol, exp_pol(2));
`ifdef MLP_IN_PACKER_ERRCNT_EN
        chk("short_errcnt", a_err_count, 16'd1);
`endif
        a_frame(4, N1, N1 - 1);
        chk("after_short_fv", a_fv, 1'b1);
        chk("after_short_mag", a_mag, exp_mag(4));
        chk("after_short_pol", a_pol, exp_pol(4));
        idle(1);
        chk("short_fe_count", a_fe_cnt - fe0, 1);
        chk("short_fv_count", a_fv_cnt - fv0, 1);

        // Long frame: 98 words without s_last, then 5 more ending with s_last
        fv0 = a_fv_cnt;
        fe0 = a_fe_cnt;
        a_frame(5, N1, -1);
        a_frame(6, 5, 4);
        idle(1);
        chk("long_fe_count", a_fe_cnt - fe0, 1);
        chk("long_fv_count", a_fv_cnt - fv0, 0);
        chk("long_mag_hold", a_mag, exp_mag(4));
        chk("long_pol_hold", a_pol, exp_pol(4));
`ifdef MLP_IN_PACKER_ERRCNT_EN
        chk("long_errcnt", a_err_count, 16'd2);
`endif
        a_frame(7, N1, N1 - 1);
        chk("after_long_fv", a_fv, 1'b1);
        chk("after_long_mag", a_mag, exp_mag(7));
        chk("after_long_pol", a_pol, exp_pol(7));
        idle(1);
        chk("after_long_fe_count", a_fe_cnt - fe0, 1);

        // Reset in the middle of a frame (after word 50)
        a_frame(8, 51, -1);
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", a_ready, 1'b0);
        @(posedge clk); #1;
        chk("midrst_mag", a_mag, '0);
        chk("midrst_pol", a_pol, '0);
        chk("midrst_fv", a_fv, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
`ifdef MLP_IN_PACKER_ERRCNT_EN
        chk("midrst_errcnt", a_err_count, 16'd0);
`endif
        a_frame(9, N1, N1 - 1);
        chk("after_rst_fv", a_fv, 1'b1);
        chk("after_rst_mag", a_mag, exp_mag(9));
        chk("after_rst_pol", a_pol, exp_pol(9));
        idle(1);

        // MIN_GAP=200 instance: second frame waits, pulses exactly 200 cycles apart
        fv0 = b_fv_cnt;
        b_frame(10, N1, N1 - 1);
        chk("gap_fv1", b_fv, 1'b1);
        chk("gap_mag1", b_mag, exp_mag(10));
        chk("gap_pol1", b_pol, exp_pol(10));
        b_frame(11, N1, N1 - 1);
        chk("gap_fv_wait", b_fv, 1'b0);
        chk("gap_ready_wait", b_ready, 1'b0);
        chk("gap_mag_hold", b_mag, exp_mag(10));
        chk("gap_pol_hold", b_pol, exp_pol(10));
        chk("gap_fill_stalls", b_stalls, 0);
        b_stalls = 0;
        b_send(gen_word(12, 0), 1'b0);
        chk("gap_wait_cycles", b_stalls, 102);
        idle(2);
        chk("gap_pulses", b_fv_cnt - fv0, 2);
        chk("gap_spacing", b_fv_last - b_fv_prev, 200);
        chk("gap_mag2", b_mag, exp_mag(11));
        chk("gap_pol2", b_pol, exp_pol(11));

        chk("a_timeout", a_timeout, 1'b0);
        chk("b_timeout", b_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
